// File: rtl/proc_pkg.sv
// Shared types for the 13-bit processor control path: stage encoding and memory opcodes.
package proc_pkg;

  localparam int INST_W = 13;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } stage_t;

  localparam logic [3:0] OP_STORE = 4'b1110;
  localparam logic [3:0] OP_LOAD  = 4'b1111;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_STORE) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/fdxmw_sequencer_sat_counter.sv
// Saturating up-counter; increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fdxmw_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer owning pc and ir; one instruction in flight.
// Optional HALT-on-zero-instruction behaviour enabled by defining SEQ_HALT_EN.
module fdxmw_sequencer #(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = proc_pkg::INST_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] ir,
  output logic [2:0]        stage,
  output logic              rf_rd_en,
  output logic              alu_en,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_addr,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic              retired,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              halted
);

  import proc_pkg::*;

  stage_t          state;
  logic [PC_W-1:0] pc;
  logic [3:0]      opcode;
  logic            is_mem;
  logic            is_store;
  logic            halt_retire;

  assign opcode   = ir[12:9];
  assign is_mem   = is_mem_op(opcode);
  assign is_store = (opcode == OP_STORE);

  // imem_req is registered: it is loaded from run on entry to FETCH and, once
  // high, held until the ack so the fetch address cannot move under it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      imem_req <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_req && imem_ack) begin
            ir       <= imem_data;
            pc       <= pc + PC_W'(1);
            imem_req <= 1'b0;
            state    <= DECODE;
          end else if (!imem_req) begin
            imem_req <= run;
          end
        end
        DECODE: begin
`ifdef SEQ_HALT_EN
          if (ir == '0) state <= HALT;
          else          state <= EXECUTE;
`else
          state <= EXECUTE;
`endif
        end
        EXECUTE: state <= is_mem ? MEMORY : WRITEBACK;
        MEMORY: begin
          if (dmem_ack) begin
            if (is_store) begin
              state    <= FETCH;
              imem_req <= run;
            end else begin
              state <= WRITEBACK;
            end
          end
        end
        WRITEBACK: begin
          state    <= FETCH;
          imem_req <= run;
        end
`ifdef SEQ_HALT_EN
        HALT:    state <= HALT;
`endif
        default: state <= FETCH;
      endcase
    end
  end

`ifdef SEQ_HALT_EN
  logic halt_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              halt_done <= 1'b0;
    else if (state == HALT)  halt_done <= 1'b1;
  end

  assign halted      = (state == HALT);
  assign halt_retire = halted && !halt_done;
`else
  assign halted      = 1'b0;
  assign halt_retire = 1'b0;
`endif

  assign imem_addr = pc;
  assign stage     = state;
  assign rf_rd_en  = (state == DECODE);
  assign alu_en    = (state == EXECUTE) && !is_mem;
  assign dmem_req  = (state == MEMORY);
  assign dmem_we   = dmem_req && is_store;
  assign dmem_addr = ir[8:5];
  assign rf_we     = (state == WRITEBACK);
  // A store completes in MEMORY, so its retire pulse rides on the ack cycle.
  assign retired   = rf_we || (dmem_req && dmem_ack && is_store) || halt_retire;

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retired),
    .count (retire_cnt)
  );

endmodule

// File: tb/tb_fdxmw_sequencer.sv
// Scoreboard bench for fdxmw_sequencer: retired instructions checked against a queue of expected completions.
module tb_fdxmw_sequencer;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [12:0] imem_data = '0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, rf_rd_en, alu_en, dmem_req, dmem_we, rf_we, retired, halted;
  logic [7:0]  imem_addr;
  logic [12:0] ir;
  logic [2:0]  stage;
  logic [3:0]  dmem_addr;
  logic [15:0] retire_cnt;

  fdxmw_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir(ir), .stage(stage), .rf_rd_en(rf_rd_en), .alu_en(alu_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .retired(retired), .retire_cnt(retire_cnt), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [12:0] inst;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          model_cnt = 0;
  logic [7:0]  model_pc  = '0;

  logic [2:0]  tr[$];
  int          n_cyc, n_rfwe, n_dreq, n_alu, n_ret, n_multi;
  logic        seen_we, ret_on_ack;
  logic [3:0]  seen_addr;
  logic [7:0]  fetch_addr;

  // Scoreboard: each retire pulse must match the oldest fetched instruction.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && retired) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_retire ir=%h cnt=%0d", ir, retire_cnt);
      end else begin
        e = sb.pop_front();
        if (ir !== e.inst || retire_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL sb_retire got ir=%h cnt=%0d want ir=%h cnt=%0d", ir, retire_cnt, e.inst, e.cnt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic run_instr(input logic [12:0] inst, input int dly, input logic run_after);
    int  wait_m = 0;
    bit  started = 0, fetched = 0, done = 0;
    tr.delete();
    n_cyc = 0; n_rfwe = 0; n_dreq = 0; n_alu = 0; n_ret = 0;
    seen_we = 1'b0; seen_addr = '0; ret_on_ack = 1'b0; fetch_addr = '0;
    imem_data = inst;
    for (int g = 0; g < 80 && !done; g++) begin
      @(negedge clk);
      imem_ack = (stage == FETCH) && imem_req && !fetched;
      dmem_ack = (stage == MEMORY) && (wait_m == dly);
      if (stage == MEMORY) wait_m++;
      #1;
      if (imem_req) started = 1;
      if (started) begin
        n_cyc++;
        tr.push_back(stage);
        if (imem_ack && imem_req) begin
          fetched = 1;
          fetch_addr = imem_addr;
          sb.push_back('{inst: inst, cnt: model_cnt[15:0]});
          model_cnt++;
          model_pc++;
        end
        if (int'(rf_rd_en) + int'(alu_en) + int'(dmem_req) + int'(rf_we) > 1) n_multi++;
        if (rf_we) n_rfwe++;
        if (alu_en) n_alu++;
        if (dmem_req) begin
          n_dreq++;
          seen_we = dmem_we;
          seen_addr = dmem_addr;
        end
        if (retired) begin
          n_ret++;
          ret_on_ack = dmem_ack;
          done = 1;
          if (!run_after) run = 1'b0;
        end
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL run_instr_timeout inst=%h stage=%0d", inst, stage);
    end
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b1;
    #12;
    n_tests++;
    if (stage !== FETCH || pc_chk(8'h00) || ir !== 13'h0 || retire_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got stage=%0d pc=%h ir=%h cnt=%0d want 0/00/0000/0", stage, imem_addr, ir, retire_cnt);
    end
    n_tests++;
    if ({imem_req, rf_rd_en, alu_en, dmem_req, dmem_we, rf_we, retired, halted} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_strobes got %b want 00000000",
               {imem_req, rf_rd_en, alu_en, dmem_req, dmem_we, rf_we, retired, halted});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
    model_pc = '0;
  endtask

  function automatic bit pc_chk(input logic [7:0] want);
    return imem_addr !== want;
  endfunction

  task automatic test_alu();
    logic [2:0] ex[4];
    ex = '{FETCH, DECODE, EXECUTE, WRITEBACK};
    run_instr(13'h0A5A, 0, 1'b1);
    n_tests++;
    if (n_cyc !== 4 || tr.size() != 4) begin
      n_fail++; $display("FAIL alu_latency got %0d want 4", n_cyc);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (tr[i] !== ex[i]) begin
          n_fail++; $display("FAIL alu_stage[%0d] got %0d want %0d", i, tr[i], ex[i]);
        end
      end
    end
    n_tests++;
    if (n_rfwe !== 1 || n_alu !== 1 || n_dreq !== 0) begin
      n_fail++; $display("FAIL alu_strobes got rf_we=%0d alu=%0d dreq=%0d want 1/1/0", n_rfwe, n_alu, n_dreq);
    end
    n_tests++;
    if (fetch_addr !== 8'h00 || imem_addr !== 8'h01 || retire_cnt !== 16'd1) begin
      n_fail++; $display("FAIL alu_pc_cnt got fa=%h pc=%h cnt=%0d want 00/01/1", fetch_addr, imem_addr, retire_cnt);
    end
  endtask

  task automatic test_load();
    run_instr(13'h1F0A, 3, 1'b1);
    n_tests++;
    if (n_dreq !== 4 || seen_we !== 1'b0 || seen_addr !== 4'h8 || n_rfwe !== 1 || n_alu !== 0 || n_cyc !== 8) begin
      n_fail++;
      $display("FAIL load_wait got dreq=%0d we=%b addr=%h rfwe=%0d alu=%0d cyc=%0d want 4/0/8/1/0/8",
               n_dreq, seen_we, seen_addr, n_rfwe, n_alu, n_cyc);
    end
    n_tests++;
    if (tr.size() != 8 || tr[7] !== WRITEBACK) begin
      n_fail++; $display("FAIL load_last_stage got size=%0d want WRITEBACK last", tr.size());
    end
    run_instr(13'h1F0A, 0, 1'b1);
    n_tests++;
    if (n_cyc !== 5) begin
      n_fail++; $display("FAIL load_latency got %0d want 5", n_cyc);
    end
  endtask

  task automatic test_store();
    run_instr(13'h1D03, 2, 1'b1);
    n_tests++;
    if (seen_we !== 1'b1 || seen_addr !== 4'h8 || n_rfwe !== 0 || ret_on_ack !== 1'b1 || n_cyc !== 6) begin
      n_fail++;
      $display("FAIL store_wait got we=%b addr=%h rfwe=%0d ret_on_ack=%b cyc=%0d want 1/8/0/1/6",
               seen_we, seen_addr, n_rfwe, ret_on_ack, n_cyc);
    end
    run_instr(13'h1D03, 0, 1'b1);
    n_tests++;
    if (n_cyc !== 4 || stage !== FETCH) begin
      n_fail++; $display("FAIL store_latency got cyc=%0d stage=%0d want 4/0", n_cyc, stage);
    end
    n_tests++;
    if (imem_addr !== model_pc || retire_cnt !== model_cnt[15:0]) begin
      n_fail++; $display("FAIL store_pc_cnt got pc=%h cnt=%0d want %h/%0d", imem_addr, retire_cnt, model_pc, model_cnt);
    end
  endtask

  task automatic test_run_gate();
    int bad = 0;
    run_instr(13'h0A5A, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (imem_req !== 1'b0 || imem_addr !== model_pc || stage !== FETCH) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL run_gate_idle got %0d bad cycles (req=%b pc=%h) want 0", bad, imem_req, imem_addr);
    end
    run = 1'b1;
    run_instr(13'h0A5A, 0, 1'b1);
    n_tests++;
    if (n_cyc !== 4 || imem_addr !== model_pc) begin
      n_fail++; $display("FAIL run_gate_resume got cyc=%0d pc=%h want 4/%h", n_cyc, imem_addr, model_pc);
    end
  endtask

  task automatic test_wrap();
    while (model_pc != 8'hFF) run_instr(13'h0A5A, 0, 1'b1);
    run_instr(13'h0A5A, 0, 1'b1);
    n_tests++;
    if (fetch_addr !== 8'hFF || imem_addr !== 8'h00) begin
      n_fail++; $display("FAIL pc_wrap got fa=%h pc=%h want ff/00", fetch_addr, imem_addr);
    end
    n_tests++;
    if (retire_cnt !== model_cnt[15:0]) begin
      n_fail++; $display("FAIL wrap_cnt got %0d want %0d", retire_cnt, model_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit reached = 0;
    imem_data = 13'h1D03;
    for (int g = 0; g < 20 && !reached; g++) begin
      @(negedge clk);
      imem_ack = (stage == FETCH) && imem_req;
      dmem_ack = 1'b0;
      #1;
      if (stage == MEMORY) reached = 1;
    end
    imem_ack = 1'b0;
    n_tests++;
    if (!reached || dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_setup got reached=%0d dmem_req=%b want 1/1", reached, dmem_req);
    end
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dmem_req !== 1'b0 || stage !== FETCH || imem_addr !== 8'h00 || retired !== 1'b0 || ir !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_mid got dreq=%b stage=%0d pc=%h ret=%b ir=%h want 0/0/00/0/0000",
               dmem_req, stage, imem_addr, retired, ir);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
    model_pc = '0;
    n_tests++;
    if (retire_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid_cnt got %0d want 0", retire_cnt);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    run_instr(13'h0000, 0, 1'b1);
`ifdef SEQ_HALT_EN
    n_tests++;
    if (n_cyc !== 3 || tr.size() != 3 || tr[2] !== HALT || n_rfwe !== 0 || n_ret !== 1) begin
      n_fail++; $display("FAIL halt_entry got cyc=%0d rfwe=%0d ret=%0d want 3/0/1", n_cyc, n_rfwe, n_ret);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (halted !== 1'b1 || imem_req !== 1'b0 || retired !== 1'b0 || stage !== HALT) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL halt_hold got %0d bad cycles want 0", bad);
    end
`else
    n_tests++;
    if (n_cyc !== 4 || tr.size() != 4 || tr[3] !== WRITEBACK || n_rfwe !== 1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL zero_inst_alu got cyc=%0d rfwe=%0d halted=%b want 4/1/0", n_cyc, n_rfwe, halted);
    end
    run_instr(13'h0A5A, 0, 1'b1);
    n_tests++;
    if (n_cyc !== 4 || halted !== 1'b0 || bad != 0) begin
      n_fail++; $display("FAIL zero_inst_continue got cyc=%0d halted=%b want 4/0", n_cyc, halted);
    end
`endif
  endtask

  initial begin
    n_multi = 0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_run_gate();
    test_wrap();
    test_reset_mid();
    test_halt();
    #30;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_pending got %0d unretired want 0", sb.size());
    end
    n_tests++;
    if (n_multi != 0) begin
      n_fail++; $display("FAIL strobe_exclusive got %0d overlapping cycles want 0", n_multi);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
